s2_mem_arbiter: RTL and testbench

- Shares one on-chip RAM s2 slave port (background_mem or pic_mem) between two fabric-side requesters: req0 = display scan-out reader, req1 = sprite/tile writer.
- Round-robin arbitration with a bounded burst allowance, so scan-out cannot be starved.
- Registered memory-side outputs.
- Tagged read-return pipeline that routes s2 readdata back to the requester that issued the read.

---
 rtl/lt24_mem_pkg.sv | 27 ++
 rtl/s2_mem_arbiter_rr_arb2.sv | 49 ++++
 rtl/s2_mem_arbiter.sv | 129 ++++++++++++
 tb/tb_s2_mem_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lt24_mem_pkg.sv
// rtl/lt24_mem_pkg.sv - shared requester indices, widths and command/tag types for the s2 memory arbiter
package lt24_mem_pkg;

    localparam int REQ_SCAN   = 0;
    localparam int REQ_SPRITE = 1;

    localparam int BG_ADDR_W  = 13;
    localparam int PIC_ADDR_W = 12;

    // Command fields are sized for the widest RAM instance; narrower ports zero-extend.
    localparam int CMD_ADDR_W = BG_ADDR_W;
    localparam int CMD_DATA_W = 16;
    localparam int CMD_BE_W   = CMD_DATA_W / 8;

    typedef struct packed {
        logic                  write;
        logic [CMD_ADDR_W-1:0] address;
        logic [CMD_DATA_W-1:0] writedata;
        logic [CMD_BE_W-1:0]   byteenable;
    } mem_cmd_t;

    typedef struct packed {
        logic valid;
        logic tag;
    } rd_tag_t;

endpackage

// File: rtl/s2_mem_arbiter_rr_arb2.sv
// rtl/s2_mem_arbiter_rr_arb2.sv - 2-way round-robin arbiter with a bounded burst allowance, one-hot grant
module rr_arb2 #(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    localparam int               CNT_W   = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(MAX_BURST - 1);

    logic             rr_ptr;
    logic [CNT_W-1:0] burst_cnt;
    logic             gnt_idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = rr_ptr;
        case (req)
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
            // Under contention the last owner keeps the port until its allowance runs out.
            2'b11:   gnt_idx = (burst_cnt < CNT_LIM) ? rr_ptr : ~rr_ptr;
            default: gnt_idx = rr_ptr;
        endcase
        if (|req) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= 1'b0;
            burst_cnt <= '0;
        end else if (!(|req)) begin
            burst_cnt <= '0;
        end else begin
            if (gnt_idx == rr_ptr) begin
                burst_cnt <= (burst_cnt == CNT_LIM) ? burst_cnt : burst_cnt + CNT_W'(1);
            end else begin
                burst_cnt <= '0;
            end
            rr_ptr <= gnt_idx;
        end
    end

endmodule

// File: rtl/s2_mem_arbiter.sv
// rtl/s2_mem_arbiter.sv - shares one on-chip RAM s2 port between scan-out and sprite requesters, tagged read return
module s2_mem_arbiter
    import lt24_mem_pkg::*;
#(
    parameter int ADDR_W       = 13,
    parameter int DATA_W       = 16,
    parameter int BE_W         = 2,
    parameter int READ_LATENCY = 1,
    parameter int MAX_BURST    = 4
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,

    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic              r0_write,
    input  logic [ADDR_W-1:0] r0_address,
    input  logic [DATA_W-1:0] r0_writedata,
    input  logic [BE_W-1:0]   r0_byteenable,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_readdata,

    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic              r1_write,
    input  logic [ADDR_W-1:0] r1_address,
    input  logic [DATA_W-1:0] r1_writedata,
    input  logic [BE_W-1:0]   r1_byteenable,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_readdata,

    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_clken,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic [BE_W-1:0]   mem_byteenable,
    input  logic [DATA_W-1:0] mem_readdata
);

    logic [1:0]               gnt;
    mem_cmd_t                 cmd0;
    mem_cmd_t                 cmd1;
    mem_cmd_t                 sel_cmd;
    rd_tag_t [READ_LATENCY:0] tag_pipe;
    rd_tag_t                  tag_exit;

    rr_arb2 #(
        .MAX_BURST(MAX_BURST)
    ) u_arb (
        .clk  (clk_clk),
        .rst_n(reset_reset_n),
        .req  ({r1_valid, r0_valid}),
        .gnt  (gnt)
    );

    assign r0_ready = gnt[REQ_SCAN];
    assign r1_ready = gnt[REQ_SPRITE];

    assign cmd0 = '{write:      r0_write,
                    address:    CMD_ADDR_W'(r0_address),
                    writedata:  CMD_DATA_W'(r0_writedata),
                    byteenable: CMD_BE_W'(r0_byteenable)};
    assign cmd1 = '{write:      r1_write,
                    address:    CMD_ADDR_W'(r1_address),
                    writedata:  CMD_DATA_W'(r1_writedata),
                    byteenable: CMD_BE_W'(r1_byteenable)};

    assign sel_cmd  = gnt[REQ_SPRITE] ? cmd1 : cmd0;
    assign tag_exit = tag_pipe[READ_LATENCY];

    // Address and data hold between commands; only chipselect and write drop.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            mem_address    <= '0;
            mem_chipselect <= 1'b0;
            mem_clken      <= 1'b0;
            mem_write      <= 1'b0;
            mem_writedata  <= '0;
            mem_byteenable <= '0;
        end else begin
            mem_clken <= 1'b1;
            if (|gnt) begin
                mem_chipselect <= 1'b1;
                mem_write      <= sel_cmd.write;
                mem_address    <= sel_cmd.address[ADDR_W-1:0];
                mem_writedata  <= sel_cmd.writedata[DATA_W-1:0];
                mem_byteenable <= sel_cmd.byteenable[BE_W-1:0];
            end else begin
                mem_chipselect <= 1'b0;
                mem_write      <= 1'b0;
            end
        end
    end

    // Stage 0 lines up with the issue register; the last stage lines up with valid readdata.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            tag_pipe <= '0;
        end else begin
            tag_pipe[0] <= '{valid: (|gnt) & ~sel_cmd.write, tag: gnt[REQ_SPRITE]};
            for (int i = 1; i <= READ_LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r0_rvalid   <= 1'b0;
            r1_rvalid   <= 1'b0;
            r0_readdata <= '0;
            r1_readdata <= '0;
        end else begin
            r0_rvalid <= 1'b0;
            r1_rvalid <= 1'b0;
            if (tag_exit.valid) begin
                if (tag_exit.tag) begin
                    r1_rvalid   <= 1'b1;
                    r1_readdata <= mem_readdata;
                end else begin
                    r0_rvalid   <= 1'b1;
                    r0_readdata <= mem_readdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_s2_mem_arbiter.sv
// tb/tb_s2_mem_arbiter.sv - self-checking bench for s2_mem_arbiter at READ_LATENCY 1 and 2
module tb_s2_mem_arbiter;

    localparam int AW   = 13;
    localparam int DW   = 16;
    localparam int BW   = 2;
    localparam int MAXB = 4;

    typedef struct {
        int             due;
        int             tag;
        logic [DW-1:0]  data;
    } ret_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          r0_valid = 1'b0, r0_write = 1'b0, r1_valid = 1'b0, r1_write = 1'b0;
    logic [AW-1:0] r0_address = '0, r1_address = '0;
    logic [DW-1:0] r0_writedata = '0, r1_writedata = '0;
    logic [BW-1:0] r0_byteenable = '0, r1_byteenable = '0;

    wire  [1:0]    rdy_a, rv_a, rdy_b, rv_b;
    wire           cs_a, clken_a, we_a, cs_b, clken_b, we_b;
    wire  [AW-1:0] addr_a, addr_b;
    wire  [DW-1:0] wd_a, wd_b, d0_a, d1_a, d0_b, d1_b;
    wire  [BW-1:0] be_a, be_b;
    logic [DW-1:0] rd_a, rd_b, rd_b1;

    s2_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .READ_LATENCY(1), .MAX_BURST(MAXB)) u_dut (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(rdy_a[0]), .r0_write(r0_write), .r0_address(r0_address),
        .r0_writedata(r0_writedata), .r0_byteenable(r0_byteenable), .r0_rvalid(rv_a[0]), .r0_readdata(d0_a),
        .r1_valid(r1_valid), .r1_ready(rdy_a[1]), .r1_write(r1_write), .r1_address(r1_address),
        .r1_writedata(r1_writedata), .r1_byteenable(r1_byteenable), .r1_rvalid(rv_a[1]), .r1_readdata(d1_a),
        .mem_address(addr_a), .mem_chipselect(cs_a), .mem_clken(clken_a), .mem_write(we_a),
        .mem_writedata(wd_a), .mem_byteenable(be_a), .mem_readdata(rd_a)
    );

    s2_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .READ_LATENCY(2), .MAX_BURST(MAXB)) u_dut2 (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(rdy_b[0]), .r0_write(r0_write), .r0_address(r0_address),
        .r0_writedata(r0_writedata), .r0_byteenable(r0_byteenable), .r0_rvalid(rv_b[0]), .r0_readdata(d0_b),
        .r1_valid(r1_valid), .r1_ready(rdy_b[1]), .r1_write(r1_write), .r1_address(r1_address),
        .r1_writedata(r1_writedata), .r1_byteenable(r1_byteenable), .r1_rvalid(rv_b[1]), .r1_readdata(d1_b),
        .mem_address(addr_b), .mem_chipselect(cs_b), .mem_clken(clken_b), .mem_write(we_b),
        .mem_writedata(wd_b), .mem_byteenable(be_b), .mem_readdata(rd_b)
    );

    function automatic logic [DW-1:0] init_word(input int i);
        case (i)
            'h0010:  return 16'hBEEF;
            'h0001:  return 16'h1111;
            'h0002:  return 16'h2222;
            'h1FFF:  return 16'hFFFF;
            default: return DW'(i * 7 + 16'h3C00);
        endcase
    endfunction

    // s2 RAM stand-in: first instance owns writes, each instance gets its own read latency.
    logic [DW-1:0] ram [2**AW];
    initial begin
        for (int i = 0; i < 2**AW; i++) ram[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (cs_a && clken_a) begin
                if (we_a) begin
                    if (be_a[0]) ram[addr_a][7:0]  <= wd_a[7:0];
                    if (be_a[1]) ram[addr_a][15:8] <= wd_a[15:8];
                end else begin
                    rd_a <= ram[addr_a];
                end
            end
            if (cs_b && clken_b && !we_b) rd_b1 <= ram[addr_b];
            rd_b <= rd_b1;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model
    logic [DW-1:0] shadow [2**AW];
    int            cyc, m_last, m_run, g;
    ret_t          q1[$], q2[$];
    logic          e_cs, e_we, e_clken;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic [BW-1:0] e_be;
    logic [1:0]    e_rdy, e_rv_a, e_rv_b;
    logic [DW-1:0] e_rd_a [2];
    logic [DW-1:0] e_rd_b [2];

    task automatic check_dut(input string p, input logic [1:0] rdy, input logic cs, input logic we,
                             input logic clken, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                             input logic [BW-1:0] be, input logic [1:0] rv, input logic [DW-1:0] d0,
                             input logic [DW-1:0] d1, input logic [1:0] erv, input logic [DW-1:0] ed0,
                             input logic [DW-1:0] ed1, input bit chk_rdy);
        if (chk_rdy) check({p, ".ready"}, 32'(rdy), 32'(e_rdy));
        check({p, ".mem_chipselect"}, 32'(cs), 32'(e_cs));
        check({p, ".mem_write"}, 32'(we), 32'(e_we));
        check({p, ".mem_clken"}, 32'(clken), 32'(e_clken));
        check({p, ".mem_address"}, 32'(addr), 32'(e_addr));
        check({p, ".mem_writedata"}, 32'(wd), 32'(e_wd));
        check({p, ".mem_byteenable"}, 32'(be), 32'(e_be));
        check({p, ".rvalid"}, 32'(rv), 32'(erv));
        check({p, ".r0_readdata"}, 32'(d0), 32'(ed0));
        check({p, ".r1_readdata"}, 32'(d1), 32'(ed1));
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [BW-1:0] be;
        logic          w;
        for (int i = 0; i < 2**AW; i++) shadow[i] = init_word(i);
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            e_rv_a = 2'b00;
            e_rv_b = 2'b00;
            if (!rst_n) begin
                m_last = 0; m_run = 0; g = -1;
                q1.delete(); q2.delete();
                {e_cs, e_we, e_clken, e_addr, e_wd, e_be, e_rdy} = '0;
                e_rd_a = '{default: '0};
                e_rd_b = '{default: '0};
                check_dut("L1", rdy_a, cs_a, we_a, clken_a, addr_a, wd_a, be_a, rv_a, d0_a, d1_a, e_rv_a, e_rd_a[0], e_rd_a[1], 1'b0);
                check_dut("L2", rdy_b, cs_b, we_b, clken_b, addr_b, wd_b, be_b, rv_b, d0_b, d1_b, e_rv_b, e_rd_b[0], e_rd_b[1], 1'b0);
            end else begin
                if (q1.size() > 0 && q1[0].due == cyc) begin
                    e_rv_a[q1[0].tag] = 1'b1;
                    e_rd_a[q1[0].tag] = q1[0].data;
                    void'(q1.pop_front());
                end
                if (q2.size() > 0 && q2[0].due == cyc) begin
                    e_rv_b[q2[0].tag] = 1'b1;
                    e_rd_b[q2[0].tag] = q2[0].data;
                    void'(q2.pop_front());
                end
                if (r0_valid && r1_valid) g = (m_run < MAXB - 1) ? m_last : 1 - m_last;
                else if (r0_valid)        g = 0;
                else if (r1_valid)        g = 1;
                else                      g = -1;
                e_rdy = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
                check_dut("L1", rdy_a, cs_a, we_a, clken_a, addr_a, wd_a, be_a, rv_a, d0_a, d1_a, e_rv_a, e_rd_a[0], e_rd_a[1], 1'b1);
                check_dut("L2", rdy_b, cs_b, we_b, clken_b, addr_b, wd_b, be_b, rv_b, d0_b, d1_b, e_rv_b, e_rd_b[0], e_rd_b[1], 1'b1);
                e_clken = 1'b1;
                if (g < 0) begin
                    m_run = 0;
                    e_cs  = 1'b0;
                    e_we  = 1'b0;
                end else begin
                    m_run  = (g != m_last) ? 0 : (m_run < MAXB - 1) ? m_run + 1 : m_run;
                    m_last = g;
                    w  = g ? r1_write : r0_write;
                    a  = g ? r1_address : r0_address;
                    d  = g ? r1_writedata : r0_writedata;
                    be = g ? r1_byteenable : r0_byteenable;
                    {e_cs, e_we, e_addr, e_wd, e_be} = {1'b1, w, a, d, be};
                    if (w) begin
                        if (be[0]) shadow[a][7:0]  = d[7:0];
                        if (be[1]) shadow[a][15:8] = d[15:8];
                    end else begin
                        q1.push_back('{due: cyc + 3, tag: g, data: shadow[a]});
                        q2.push_back('{due: cyc + 4, tag: g, data: shadow[a]});
                    end
                end
            end
        end
    end

    // Directed stimulus with literal expectations
    int exp_seq [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    int got;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        r0_valid = 1'b0;
        r1_valid = 1'b0;
    endtask

    task automatic drive(input int n, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [BW-1:0] be);
        if (n == 0) begin
            r0_valid = 1'b1; r0_write = w; r0_address = a; r0_writedata = d; r0_byteenable = be;
        end else begin
            r1_valid = 1'b1; r1_write = w; r1_address = a; r1_writedata = d; r1_byteenable = be;
        end
    endtask

    task automatic drain();
        idle();
        repeat (6) step();
    endtask

    initial begin
        @(negedge clk);
        check("reset.mem_clken", 32'(clken_a), 0);
        check("reset.mem_chipselect", 32'(cs_a), 0);
        check("reset.rvalid", 32'(rv_a), 0);
        step();
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("release.mem_clken_before_edge", 32'(clken_a), 0);
        step();
        @(negedge clk);
        check("release.mem_clken_after_edge", 32'(clken_a), 1);

        // Single read, both latencies
        step();
        drive(0, 1'b0, 13'h0010, 16'h0000, 2'b11);
        @(negedge clk);
        check("single.r0_ready", 32'(rdy_a), 32'b01);
        step(); idle(); @(negedge clk);
        check("single.mem_chipselect", 32'(cs_a), 1);
        check("single.mem_address", 32'(addr_a), 32'h0010);
        step(); @(negedge clk);
        check("single.early_rvalid", 32'(rv_a), 0);
        step(); @(negedge clk);
        check("single.L1_rvalid", 32'(rv_a), 32'b01);
        check("single.L1_readdata", 32'(d0_a), 32'hBEEF);
        check("single.L2_early_rvalid", 32'(rv_b), 0);
        step(); @(negedge clk);
        check("single.L2_rvalid", 32'(rv_b), 32'b01);
        check("single.L2_readdata", 32'(d0_b), 32'hBEEF);
        check("single.L1_rvalid_pulse", 32'(rv_a), 0);
        drain();

        // Contention: r1 once, r0 once, then both continuously
        drive(1, 1'b0, 13'h0020, 16'h0000, 2'b11);
        @(negedge clk);
        step(); idle();
        drive(0, 1'b0, 13'h0021, 16'h0000, 2'b11);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin
                drive(0, 1'b0, AW'(32'h100 + i), 16'h0000, 2'b11);
                drive(1, 1'b0, AW'(32'h180 + i), 16'h0000, 2'b11);
            end
            @(negedge clk);
            got = (rdy_a == 2'b01) ? 0 : (rdy_a == 2'b10) ? 1 : -1;
            check("contention.grant", 32'(got), 32'(exp_seq[i]));
            check("contention.one_ready", 32'(rdy_a == 2'b11), 0);
            step();
        end
        drain();

        // Interleaved reads from both requesters
        drive(0, 1'b0, 13'h0001, 16'h0000, 2'b11);
        @(negedge clk);
        step(); idle();
        drive(1, 1'b0, 13'h0002, 16'h0000, 2'b11);
        @(negedge clk);
        step(); idle(); @(negedge clk);
        check("interleave.no_early_rvalid", 32'(rv_a), 0);
        step(); @(negedge clk);
        check("interleave.r0_rvalid", 32'(rv_a), 32'b01);
        check("interleave.r0_readdata", 32'(d0_a), 32'h1111);
        step(); @(negedge clk);
        check("interleave.r1_rvalid", 32'(rv_a), 32'b10);
        check("interleave.r1_readdata", 32'(d1_a), 32'h2222);
        check("interleave.r0_hold", 32'(d0_a), 32'h1111);
        drain();

        // Byte-lane write by r1, then read back by r0
        drive(1, 1'b1, 13'h1FFF, 16'h0A5A, 2'b10);
        @(negedge clk);
        step(); idle();
        drive(0, 1'b0, 13'h1FFF, 16'h0000, 2'b11);
        @(negedge clk);
        step(); idle();
        repeat (2) step();
        @(negedge clk);
        check("raw.r0_rvalid", 32'(rv_a), 32'b01);
        check("raw.r0_readdata", 32'(d0_a), 32'h0AFF);
        drain();

        // Reset while a read is in flight
        drive(0, 1'b0, 13'h0030, 16'h0000, 2'b11);
        @(negedge clk);
        step(); idle(); @(negedge clk);
        check("midreset.inflight_cs", 32'(cs_a), 1);
        step();
        rst_n = 1'b0;
        #1;
        check("midreset.mem_chipselect", 32'(cs_a), 0);
        check("midreset.mem_clken", 32'(clken_a), 0);
        check("midreset.mem_address", 32'(addr_a), 0);
        check("midreset.rvalid_L1", 32'(rv_a), 0);
        check("midreset.rvalid_L2", 32'(rv_b), 0);
        step();
        step();
        rst_n = 1'b1;
        drive(0, 1'b1, 13'h0040, 16'h1234, 2'b11);
        drive(1, 1'b1, 13'h0041, 16'h5678, 2'b11);
        @(negedge clk);
        check("midreset.first_grant", 32'(rdy_a), 32'b01);
        step(); idle();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("midreset.no_rvalid", 32'({rv_b, rv_a}), 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
